// File: rtl/brom_pkg.sv
// Shared widths, requester count and tag type for the two-port boot ROM arbiter.
package brom_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 64;
    localparam int NUM_REQ    = 2;
    localparam int FIFO_DEPTH = 2;

    typedef logic [$clog2(NUM_REQ)-1:0] tag_t;

endpackage

// File: rtl/brom_arbiter_if.sv
// Request/response bundle between the two requesters (master) and the arbiter (slave).
interface brom_arbiter_if #(
    parameter int ADDR_W = brom_pkg::ADDR_W,
    parameter int DATA_W = brom_pkg::DATA_W
);

    // A transfer happens on either channel in any cycle where valid and ready are both 1.
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic              resp0_valid;
    logic              resp0_ready;
    logic [DATA_W-1:0] resp0_data;
    logic              resp1_valid;
    logic              resp1_ready;
    logic [DATA_W-1:0] resp1_data;

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, resp0_ready, resp1_ready,
        input  req0_ready, req1_ready, resp0_valid, resp0_data, resp1_valid, resp1_data
    );

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, resp0_ready, resp1_ready,
        output req0_ready, req1_ready, resp0_valid, resp0_data, resp1_valid, resp1_data
    );

endinterface

// File: rtl/brom_256x64.sv
// 256x64 boot ROM with a registered output; the word appears the cycle after addr is sampled.
module brom_256x64
    import brom_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] y
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            y <= '0;
        end else begin
            case (addr)
                8'd0:    y <= 64'h44881112_3100C1A1;
                8'd1:    y <= 64'h77101937_4014A2B2;
                8'd2:    y <= 64'h89239447_2932DAC3;
                8'd3:    y <= 64'h34784782_7910FCD4;
                8'd4:    y <= 64'hAD127839_139A12E5;
                8'd5:    y <= 64'h48572015_722903F6;
                8'd6:    y <= 64'hFF237248_24742117;
                8'd7:    y <= 64'h13874949_28924428;
                default: y <= '0;
            endcase
        end
    end

endmodule

// File: rtl/brom_arbiter.sv
// Round-robin time-sharing of one synchronous ROM between two requesters,
// each with a 2-entry in-order response FIFO and credit-style outstanding count.
module brom_arbiter #(
    parameter int ADDR_W = brom_pkg::ADDR_W,
    parameter int DATA_W = brom_pkg::DATA_W
) (
    input logic          clock,
    input logic          reset,
    brom_arbiter_if.slave bus
);

    import brom_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] resp_ready;
    logic [NUM_REQ-1:0] resp_valid;
    logic [NUM_REQ-1:0] resp_hs;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] push;
    logic [ADDR_W-1:0]  req_addr [NUM_REQ];
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_y;

    tag_t               ptr;
    logic               inflight_valid;
    tag_t               inflight_tag;
    logic [1:0]         out_cnt  [NUM_REQ];
    logic [1:0]         fifo_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] fifo_wr;
    logic [NUM_REQ-1:0] fifo_rd;
    logic [DATA_W-1:0]  fifo_mem [NUM_REQ][FIFO_DEPTH];

    assign req_valid   = {bus.req1_valid, bus.req0_valid};
    assign resp_ready  = {bus.resp1_ready, bus.resp0_ready};
    assign req_addr[0] = bus.req0_addr;
    assign req_addr[1] = bus.req1_addr;

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.resp0_valid = resp_valid[0];
    assign bus.resp1_valid = resp_valid[1];
    assign bus.resp0_data  = fifo_mem[0][fifo_rd[0]];
    assign bus.resp1_data  = fifo_mem[1][fifo_rd[1]];

    always_comb begin
        resp_valid = '0;
        resp_hs    = '0;
        elig       = '0;
        push       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (fifo_cnt[i] != 2'd0);
            resp_hs[i]    = resp_valid[i] && resp_ready[i];
            // A full credit frees up in the same cycle its head response is consumed.
            elig[i]       = (out_cnt[i] < 2'd2) || ((out_cnt[i] == 2'd2) && resp_hs[i]);
            push[i]       = inflight_valid && (inflight_tag == tag_t'(i));
        end
    end

    always_comb begin
        cand     = req_valid & elig;
        grant    = '0;
        rom_addr = req_addr[0];
        if (reset) begin
            if (&cand) grant = ptr[0] ? 2'b10 : 2'b01;
            else       grant = cand;
        end
        if (grant[1]) rom_addr = req_addr[1];
    end

    brom_256x64 u_rom (
        .clock (clock),
        .reset (reset),
        .addr  (rom_addr),
        .y     (rom_y)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr            <= '0;
            inflight_valid <= 1'b0;
            inflight_tag   <= '0;
            fifo_wr        <= '0;
            fifo_rd        <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                out_cnt[i]  <= '0;
                fifo_cnt[i] <= '0;
            end
        end else begin
            inflight_valid <= |grant;
            inflight_tag   <= tag_t'(grant[1]);
            // Favour whoever lost: granting 0 points at 1 and vice versa.
            if (|grant) ptr <= tag_t'(grant[0]);
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({grant[i], resp_hs[i]})
                    2'b10:   out_cnt[i] <= out_cnt[i] + 2'd1;
                    2'b01:   out_cnt[i] <= out_cnt[i] - 2'd1;
                    default: out_cnt[i] <= out_cnt[i];
                endcase
                case ({push[i], resp_hs[i]})
                    2'b10:   fifo_cnt[i] <= fifo_cnt[i] + 2'd1;
                    2'b01:   fifo_cnt[i] <= fifo_cnt[i] - 2'd1;
                    default: fifo_cnt[i] <= fifo_cnt[i];
                endcase
                if (push[i])    fifo_wr[i] <= ~fifo_wr[i];
                if (resp_hs[i]) fifo_rd[i] <= ~fifo_rd[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) fifo_mem[i][fifo_wr[i]] <= rom_y;
        end
    end

endmodule

// File: tb/tb_brom_arbiter.sv
// Directed bench for brom_arbiter: reset, single read, contention, backpressure,
// streaming, out-of-range address and reset with a read in flight.
module tb_brom_arbiter;

    import brom_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [DATA_W-1:0] exp_q[$];

    brom_arbiter_if bus ();

    brom_arbiter dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] rom_word(input int a);
        case (a)
            0:       return 64'h44881112_3100C1A1;
            1:       return 64'h77101937_4014A2B2;
            2:       return 64'h89239447_2932DAC3;
            3:       return 64'h34784782_7910FCD4;
            4:       return 64'hAD127839_139A12E5;
            5:       return 64'h48572015_722903F6;
            6:       return 64'hFF237248_24742117;
            7:       return 64'h13874949_28924428;
            default: return 64'h0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.req0_valid  = 1'b0;
        bus.req0_addr   = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_addr   = '0;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        tick();
        #1;
        total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready: got %b want 0", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req1_ready: got %b want 0", bus.req1_ready); end
        total++; if (bus.resp0_valid !== 1'b0) begin bad++; $display("FAIL reset_resp0_valid: got %b want 0", bus.resp0_valid); end
        total++; if (bus.resp1_valid !== 1'b0) begin bad++; $display("FAIL reset_resp1_valid: got %b want 0", bus.resp1_valid); end
        idle();
        reset = 1'b1;
        tick();
        total++; if (bus.resp0_valid !== 1'b0) begin bad++; $display("FAIL post_reset_resp0_valid: got %b want 0", bus.resp0_valid); end
    endtask

    task automatic test_contention;
        bus.req0_valid = 1'b1; bus.req0_addr = 8'd1;
        bus.req1_valid = 1'b1; bus.req1_addr = 8'd7;
        #1;
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL tie_req0_ready: got %b want 1", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL tie_req1_ready: got %b want 0", bus.req1_ready); end
        tick();
        bus.req0_valid = 1'b0;
        #1;
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL tie_req1_next: got %b want 1", bus.req1_ready); end
        tick();
        bus.req1_valid = 1'b0;
        #1;
        total++; if (bus.resp0_valid !== 1'b1) begin bad++; $display("FAIL tie_resp0_valid: got %b want 1", bus.resp0_valid); end
        total++; if (bus.resp0_data !== 64'h77101937_4014A2B2) begin bad++; $display("FAIL tie_resp0_data: got %h want 77101937_4014a2b2", bus.resp0_data); end
        total++; if (bus.resp1_valid !== 1'b0) begin bad++; $display("FAIL tie_resp1_early: got %b want 0", bus.resp1_valid); end
        tick();
        total++; if (bus.resp1_valid !== 1'b1) begin bad++; $display("FAIL tie_resp1_valid: got %b want 1", bus.resp1_valid); end
        total++; if (bus.resp1_data !== 64'h13874949_28924428) begin bad++; $display("FAIL tie_resp1_data: got %h want 13874949_28924428", bus.resp1_data); end
        total++; if (bus.resp0_valid !== 1'b0) begin bad++; $display("FAIL tie_resp0_drained: got %b want 0", bus.resp0_valid); end
        tick();
    endtask

    task automatic test_single;
        bus.req0_valid = 1'b1; bus.req0_addr = 8'd0;
        #1;
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        #1;
        total++; if (bus.resp0_valid !== 1'b0) begin bad++; $display("FAIL single_t1_valid: got %b want 0", bus.resp0_valid); end
        tick();
        total++; if (bus.resp0_valid !== 1'b1) begin bad++; $display("FAIL single_t2_valid: got %b want 1", bus.resp0_valid); end
        total++; if (bus.resp0_data !== 64'h44881112_3100C1A1) begin bad++; $display("FAIL single_data: got %h want 44881112_3100c1a1", bus.resp0_data); end
        tick();
        total++; if (bus.resp0_valid !== 1'b0) begin bad++; $display("FAIL single_drained: got %b want 0", bus.resp0_valid); end
    endtask

    task automatic test_backpressure;
        bus.resp1_ready = 1'b0;
        bus.req1_valid  = 1'b1; bus.req1_addr = 8'd2;
        #1;
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a2: got %b want 1", bus.req1_ready); end
        tick();
        bus.req1_addr = 8'd3;
        #1;
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a3: got %b want 1", bus.req1_ready); end
        tick();
        bus.req1_addr = 8'd4;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL bp_blocked_%0d: got %b want 0", k, bus.req1_ready); end
            if (k > 0) begin
                total++; if (bus.resp1_data !== 64'h89239447_2932DAC3) begin bad++; $display("FAIL bp_hold_%0d: got %h want 89239447_2932dac3", k, bus.resp1_data); end
            end
            tick();
        end
        bus.resp1_ready = 1'b1;
        #1;
        total++; if (bus.resp1_valid !== 1'b1) begin bad++; $display("FAIL bp_head_valid: got %b want 1", bus.resp1_valid); end
        total++; if (bus.resp1_data !== 64'h89239447_2932DAC3) begin bad++; $display("FAIL bp_head_data: got %h want 89239447_2932dac3", bus.resp1_data); end
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a4: got %b want 1", bus.req1_ready); end
        tick();
        bus.req1_valid = 1'b0;
        #1;
        total++; if (bus.resp1_data !== 64'h34784782_7910FCD4) begin bad++; $display("FAIL bp_second_data: got %h want 34784782_7910fcd4", bus.resp1_data); end
        tick();
        total++; if (bus.resp1_data !== 64'hAD127839_139A12E5) begin bad++; $display("FAIL bp_third_data: got %h want ad127839_139a12e5", bus.resp1_data); end
        total++; if (bus.resp1_valid !== 1'b1) begin bad++; $display("FAIL bp_third_valid: got %b want 1", bus.resp1_valid); end
        tick();
        total++; if (bus.resp1_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", bus.resp1_valid); end
    endtask

    task automatic test_streaming;
        logic ev;
        int   got;
        got = 0;
        exp_q.delete();
        bus.resp0_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            bus.req0_valid = (c < 8);
            bus.req0_addr  = ADDR_W'(c);
            #1;
            if (c < 8) begin
                total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL stream_accept_%0d: got %b want 1", c, bus.req0_ready); end
                exp_q.push_back(rom_word(c));
            end
            ev = (c >= 2) && (c < 10);
            total++; if (bus.resp0_valid !== ev) begin bad++; $display("FAIL stream_valid_%0d: got %b want %b", c, bus.resp0_valid, ev); end
            if (bus.resp0_valid === 1'b1 && exp_q.size() > 0) begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                got++;
                total++; if (bus.resp0_data !== e) begin bad++; $display("FAIL stream_data_%0d: got %h want %h", got, bus.resp0_data, e); end
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        total++; if (got != 8) begin bad++; $display("FAIL stream_count: got %0d want 8", got); end
    endtask

    task automatic test_out_of_range;
        bus.req0_valid = 1'b1; bus.req0_addr = 8'd200;
        #1;
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL oor_ready: got %b want 1", bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        tick();
        total++; if (bus.resp0_valid !== 1'b1) begin bad++; $display("FAIL oor_valid: got %b want 1", bus.resp0_valid); end
        total++; if (bus.resp0_data !== 64'h0) begin bad++; $display("FAIL oor_data: got %h want 0", bus.resp0_data); end
        tick();
    endtask

    task automatic test_reset_mid;
        bus.req0_valid = 1'b1; bus.req0_addr = 8'd5;
        #1;
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL rmid_accept: got %b want 1", bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_addr = 8'd1;
        reset = 1'b0;
        #1;
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_reset: got %b want 0", bus.req1_ready); end
        tick();
        reset = 1'b1;
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (bus.resp0_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_resp_%0d: got %b want 0", k, bus.resp0_valid); end
            tick();
        end
        bus.req0_valid = 1'b1; bus.req0_addr = 8'd6;
        bus.req1_valid = 1'b1; bus.req1_addr = 8'd3;
        #1;
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL rmid_tie_req0: got %b want 1", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL rmid_tie_req1: got %b want 0", bus.req1_ready); end
        tick();
        bus.req0_valid = 1'b0;
        tick();
        bus.req1_valid = 1'b0;
        #1;
        total++; if (bus.resp0_data !== 64'hFF237248_24742117) begin bad++; $display("FAIL rmid_resp0_data: got %h want ff237248_24742117", bus.resp0_data); end
        tick();
        total++; if (bus.resp1_data !== 64'h34784782_7910FCD4) begin bad++; $display("FAIL rmid_resp1_data: got %h want 34784782_7910fcd4", bus.resp1_data); end
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_streaming();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
